// File: rtl/cam_config_sequencer_if.sv
// Write-request / write-response channel between the camera config sequencer and an SCCB/I2C master.
interface cam_config_sequencer_if #(
  parameter int REG_ADDR_W = 8,
  parameter int REG_DATA_W = 8
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic [REG_ADDR_W-1:0] req_addr;
  logic [REG_DATA_W-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_nack;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_nack
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rsp_valid, rsp_nack
  );
endinterface

// File: rtl/cam_config_sequencer.sv
// Walks a camera register table ({reg_addr, reg_data} words, END/DELAY markers) and issues one
// SCCB write per entry. Optional macro CFG_RETRY_EN adds up to MAX_RETRY resends after a NACK.
module cam_config_sequencer #(
  parameter int          REG_ADDR_W = 8,
  parameter int          REG_DATA_W = 8,
  parameter int          ROM_DEPTH  = 256,
  parameter int unsigned DELAY_UNIT = 250000,
`ifdef CFG_RETRY_EN
  parameter int          MAX_RETRY  = 3,
`endif
  parameter logic [REG_ADDR_W+REG_DATA_W-1:0] ROM_INIT [ROM_DEPTH] = '{default: '1},
  localparam int         ROM_AW     = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  cam_config_sequencer_if.master  bus,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ROM_AW-1:0]       entry_idx
);

  localparam int WORD_W = REG_ADDR_W + REG_DATA_W;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_ROM_WAIT = 4'd2,
    S_DECODE   = 4'd3,
    S_SEND     = 4'd4,
    S_WAIT_RSP = 4'd5,
    S_DELAY    = 4'd6,
    S_ADVANCE  = 4'd7,
    S_DONE     = 4'd8,
    S_ERROR    = 4'd9
  } state_t;

  state_t                  state_q;
  logic [WORD_W-1:0]       rom_word_q;
  logic [ROM_AW-1:0]       entry_idx_q;
  logic [31:0]             delay_cnt_q;
  logic                    req_valid_q;
  logic [REG_ADDR_W-1:0]   req_addr_q;
  logic [REG_DATA_W-1:0]   req_data_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
`ifdef CFG_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0]      retry_cnt_q;
`endif

  logic [REG_ADDR_W-1:0]   word_addr_s;
  logic [REG_DATA_W-1:0]   word_data_s;
  logic                    is_end_s;
  logic                    is_delay_s;
  logic [31:0]             delay_len_s;

  assign word_addr_s = rom_word_q[WORD_W-1:REG_DATA_W];
  assign word_data_s = rom_word_q[REG_DATA_W-1:0];
  assign is_end_s    = &rom_word_q;
  assign is_delay_s  = (&word_addr_s) & ~(&word_data_s);
  // Loaded with N-1 so the DELAY state lasts exactly N cycles before the count reaches zero.
  assign delay_len_s = ((32'(word_data_s[3:0]) + 32'd1) * DELAY_UNIT) - 32'd1;

  // Synchronous table read: the word for entry_idx presented in FETCH is valid in ROM_WAIT.
  always_ff @(posedge clk) begin
    rom_word_q <= ROM_INIT[entry_idx_q];
  end

  // Sequencer FSM with all status and request outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      entry_idx_q <= '0;
      delay_cnt_q <= 32'd0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef CFG_RETRY_EN
      retry_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q     <= S_FETCH;
            entry_idx_q <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef CFG_RETRY_EN
            retry_cnt_q <= '0;
`endif
          end
        end
        S_FETCH:    state_q <= S_ROM_WAIT;
        S_ROM_WAIT: state_q <= S_DECODE;
        S_DECODE: begin
          if (is_end_s) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (is_delay_s) begin
            state_q     <= S_DELAY;
            delay_cnt_q <= delay_len_s;
          end else begin
            state_q     <= S_SEND;
            req_valid_q <= 1'b1;
            req_addr_q  <= word_addr_s;
            req_data_q  <= word_data_s;
          end
        end
        S_SEND: begin
          if (bus.req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (bus.rsp_valid) begin
            if (!bus.rsp_nack) begin
              state_q <= S_ADVANCE;
`ifdef CFG_RETRY_EN
            end else if (retry_cnt_q < RETRY_W'(MAX_RETRY)) begin
              // Resend the same word; req_addr/req_data still hold it.
              retry_cnt_q <= retry_cnt_q + RETRY_W'(1);
              req_valid_q <= 1'b1;
              state_q     <= S_SEND;
`endif
            end else begin
              state_q <= S_ERROR;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end
        end
        S_DELAY: begin
          if (delay_cnt_q == 32'd0) begin
            state_q <= S_ADVANCE;
          end else begin
            delay_cnt_q <= delay_cnt_q - 32'd1;
          end
        end
        S_ADVANCE: begin
`ifdef CFG_RETRY_EN
          retry_cnt_q <= '0;
`endif
          // A table without END stops at its last entry instead of wrapping.
          if (entry_idx_q == ROM_AW'(ROM_DEPTH - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            entry_idx_q <= entry_idx_q + ROM_AW'(1);
            state_q     <= S_FETCH;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_valid = req_valid_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_data  = req_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign entry_idx     = entry_idx_q;

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Directed bench for cam_config_sequencer: an SCCB responder checks each write against a scoreboard
// of expected {addr, data, cycles since start/last response}; status is checked with immediate asserts.
module tb_cam_config_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  bit   sel     = 1'b0;
  logic rdy     = 1'b0;
  logic rspv    = 1'b0;
  logic nack    = 1'b0;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int last_evt  = 0;
  int n_rsp     = 0;
  int hold      = 0;
  int nack_left = 0;
  int seen      = 0;
  int rsp_cd    = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         gap;
  } exp_t;
  exp_t sb[$];

  localparam logic [15:0] ROM_A [4] = '{16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF};
  localparam logic [15:0] ROM_B [4] = '{16'h0111, 16'h0222, 16'h0333, 16'h0444};

  cam_config_sequencer_if #(.REG_ADDR_W(8), .REG_DATA_W(8)) a_bus ();
  cam_config_sequencer_if #(.REG_ADDR_W(8), .REG_DATA_W(8)) b_bus ();

  logic       busy_a, done_a, error_a, busy_b, done_b, error_b;
  logic [1:0] idx_a, idx_b;

  cam_config_sequencer #(
    .REG_ADDR_W(8), .REG_DATA_W(8), .ROM_DEPTH(4), .DELAY_UNIT(8),
`ifdef CFG_RETRY_EN
    .MAX_RETRY(3),
`endif
    .ROM_INIT(ROM_A)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .bus(a_bus),
    .busy(busy_a), .done(done_a), .error(error_a), .entry_idx(idx_a)
  );

  cam_config_sequencer #(
    .REG_ADDR_W(8), .REG_DATA_W(8), .ROM_DEPTH(4), .DELAY_UNIT(8),
`ifdef CFG_RETRY_EN
    .MAX_RETRY(3),
`endif
    .ROM_INIT(ROM_B)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .bus(b_bus),
    .busy(busy_b), .done(done_b), .error(error_b), .entry_idx(idx_b)
  );

  assign a_bus.req_ready = !sel && rdy;
  assign a_bus.rsp_valid = !sel && rspv;
  assign a_bus.rsp_nack  = !sel && nack;
  assign b_bus.req_ready = sel && rdy;
  assign b_bus.rsp_valid = sel && rspv;
  assign b_bus.rsp_nack  = sel && nack;

  logic       m_valid, m_busy, m_done, m_error;
  logic [7:0] m_addr, m_data;
  logic [1:0] m_idx;
  assign m_valid = sel ? b_bus.req_valid : a_bus.req_valid;
  assign m_addr  = sel ? b_bus.req_addr  : a_bus.req_addr;
  assign m_data  = sel ? b_bus.req_data  : a_bus.req_data;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_error = sel ? error_b : error_a;
  assign m_idx   = sel ? idx_b   : idx_a;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [7:0] d, input int g);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.gap  = g;
    sb.push_back(e);
  endtask

  task automatic pulse_start(input bit mark);
    @(negedge clk);
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    if (mark) last_evt = cyc;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (m_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(m_busy), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_status(input string tag, input logic dn, input logic er, input logic [1:0] ix);
    check({tag, "_busy"},  32'(m_busy),  32'd0);
    check({tag, "_done"},  32'(m_done),  32'(dn));
    check({tag, "_error"}, 32'(m_error), 32'(er));
    check({tag, "_idx"},   32'(m_idx),   32'(ix));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_addr"},  32'(m_addr),  32'd0);
    check({tag, "_data"},  32'(m_data),  32'd0);
    check_status(tag, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic run_t1_table(input string tag);
    expect_wr(8'h12, 8'h80, 4);
    expect_wr(8'h11, 8'h00, 9 + (0 + 1) * 8);
    pulse_start(1'b1);
    wait_idle(tag);
    check_status(tag, 1'b1, 1'b0, 2'd3);
  endtask

  // SCCB slave model and scoreboard monitor.
  initial begin : sccb_model
    forever begin
      @(negedge clk);
      rdy  = 1'b0;
      rspv = 1'b0;
      nack = 1'b0;
      if (!reset_n) begin
        seen   = 0;
        rsp_cd = 0;
      end else begin
        if (rsp_cd > 0) begin
          rsp_cd--;
          if (rsp_cd == 0) begin
            rspv = 1'b1;
            if (nack_left > 0) begin
              nack = 1'b1;
              nack_left--;
            end
            last_evt = cyc;
            n_rsp++;
          end
        end
        if (m_valid) begin
          if (seen == 0) begin
            check("req_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("req_gap", 32'(cyc - last_evt), 32'(sb[0].gap));
          end
          if (sb.size() != 0) begin
            check("req_addr", 32'(m_addr), 32'(sb[0].addr));
            check("req_data", 32'(m_data), 32'(sb[0].data));
          end
          seen++;
          if (seen > hold) begin
            rdy = 1'b1;
            if (sb.size() != 0) void'(sb.pop_front());
            seen   = 0;
            rsp_cd = 2;
          end
        end else if (seen != 0) begin
          check("valid_dropped_early", 32'(seen), 32'(hold + 1));
          seen = 0;
        end
      end
    end
  end

  initial begin : main_seq
    int n;
    int r0;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    check_reset("rst_a");
    sel = 1'b1;
    check_reset("rst_b");
    sel = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: write, 8-cycle delay, write, END
    run_t1_table("t1");

    // T2: ready held low 5 cycles per write; start from DONE clears done next cycle
    hold = 5;
    expect_wr(8'h12, 8'h80, 4);
    expect_wr(8'h11, 8'h00, 17);
    pulse_start(1'b1);
    check("t2_done_cleared", 32'(m_done), 32'd0);
    wait_idle("t2");
    check_status("t2", 1'b1, 1'b0, 2'd3);
    hold = 0;

    // T6: start while busy at entry 2 is ignored
    expect_wr(8'h12, 8'h80, 4);
    expect_wr(8'h11, 8'h00, 17);
    pulse_start(1'b1);
    n = 0;
    while (!(m_idx == 2'd2 && m_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_idx2", 32'(m_idx), 32'd2);
    pulse_start(1'b0);
    check("t6_still_busy", 32'(m_busy), 32'd1);
    wait_idle("t6");
    check_status("t6", 1'b1, 1'b0, 2'd3);

    // T5: reset while waiting in DELAY
    r0 = n_rsp;
    expect_wr(8'h12, 8'h80, 4);
    pulse_start(1'b1);
    n = 0;
    while (n_rsp == r0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_first_ack", 32'(n_rsp - r0), 32'd1);
    while (cyc < last_evt + 8) @(negedge clk);
    check("t5_in_delay_busy", 32'(m_busy), 32'd1);
    check("t5_in_delay_idx", 32'(m_idx), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset("t5_rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_t1_table("t5_rerun");

`ifdef CFG_RETRY_EN
    // T3: two NACKs on entry 0 are retried, then normal progress
    nack_left = 2;
    expect_wr(8'h12, 8'h80, 4);
    expect_wr(8'h12, 8'h80, 1);
    expect_wr(8'h12, 8'h80, 1);
    expect_wr(8'h11, 8'h00, 17);
    pulse_start(1'b1);
    wait_idle("t3_retry");
    check_status("t3_retry", 1'b1, 1'b0, 2'd3);
    // four NACKs exhaust MAX_RETRY=3
    nack_left = 4;
    expect_wr(8'h12, 8'h80, 4);
    expect_wr(8'h12, 8'h80, 1);
    expect_wr(8'h12, 8'h80, 1);
    expect_wr(8'h12, 8'h80, 1);
    pulse_start(1'b1);
    wait_idle("t3_abort");
    check_status("t3_abort", 1'b0, 1'b1, 2'd0);
`else
    // First NACK aborts with entry_idx on the failing entry
    nack_left = 1;
    expect_wr(8'h12, 8'h80, 4);
    pulse_start(1'b1);
    wait_idle("nack");
    check_status("nack", 1'b0, 1'b1, 2'd0);
`endif
    nack_left = 0;
    expect_wr(8'h12, 8'h80, 4);
    expect_wr(8'h11, 8'h00, 17);
    pulse_start(1'b1);
    check("recover_error_cleared", 32'(m_error), 32'd0);
    wait_idle("recover");
    check_status("recover", 1'b1, 1'b0, 2'd3);

    // T4: table without END stops after the last entry
    sel = 1'b1;
    expect_wr(8'h01, 8'h11, 4);
    expect_wr(8'h02, 8'h22, 5);
    expect_wr(8'h03, 8'h33, 5);
    expect_wr(8'h04, 8'h44, 5);
    pulse_start(1'b1);
    wait_idle("t4");
    check_status("t4", 1'b1, 1'b0, 2'd3);
    repeat (12) @(negedge clk);
    check_status("t4_no_wrap", 1'b1, 1'b0, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
